// File: rtl/schedule_rx_monitor_if.sv
// Schedule receive link bundle: time base, slot period and rx pulse in; lock/pulse/stat outputs back.
interface schedule_rx_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      GTB;
  logic [31:0]      scheduleEntry;
  logic             rx;
  logic             locked;
  logic             hit;
  logic             miss;
  logic             stray;
  logic [CNT_W-1:0] hitCount;
  logic [CNT_W-1:0] errCount;

  modport master (
    output GTB, scheduleEntry, rx,
    input  locked, hit, miss, stray, hitCount, errCount
  );

  modport slave (
    input  GTB, scheduleEntry, rx,
    output locked, hit, miss, stray, hitCount, errCount
  );
endinterface

// File: rtl/schedule_rx_monitor.sv
// Receive-side schedule checker: window classification of rx edges, lock FSM and stats.
// Macro SCHED_RX_COUNTERS_EN enables the saturating hitCount/errCount registers.
module schedule_rx_monitor #(
  parameter int unsigned WIN        = 4,
  parameter int unsigned LOCK_HITS  = 2,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  schedule_rx_monitor_if.slave  bus
);

  localparam int unsigned HC_W = (LOCK_HITS  < 2) ? 1 : $clog2(LOCK_HITS + 1);
  localparam int unsigned MC_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e          state_q;
  logic            rx_q;
  logic            win_q;
  logic            seen_q;
  logic [HC_W-1:0] hc_q;
  logic [MC_W-1:0] mc_q;
  logic            locked_q;
  logic            hit_q;
  logic            miss_q;
  logic            stray_q;

  logic            active_c;
  logic [31:0]     divisor_c;
  logic [31:0]     phase_c;
  logic [32:0]     upper_c;
  logic            in_win_c;
  logic            edge_c;
  logic            close_c;
  logic            hit_d;
  logic            miss_d;
  logic            stray_d;
  logic [HC_W-1:0] hc_inc_c;
  logic [MC_W-1:0] mc_inc_c;

  // Window classification; divisor forced to 1 when disabled so the modulo stays defined.
  always_comb begin
    active_c  = (bus.scheduleEntry != 32'd0);
    divisor_c = active_c ? bus.scheduleEntry : 32'd1;
    phase_c   = bus.GTB % divisor_c;
    upper_c   = {1'b0, phase_c} + 33'(WIN);
    in_win_c  = active_c && ((phase_c <= 32'(WIN)) || (upper_c >= {1'b0, bus.scheduleEntry}));
    edge_c    = bus.rx & ~rx_q;
    close_c   = win_q & ~in_win_c;
    hit_d     = active_c & edge_c & in_win_c & ~seen_q;
    stray_d   = active_c & edge_c & (~in_win_c | seen_q);
    miss_d    = active_c & close_c & ~seen_q;
    hc_inc_c  = hc_q + HC_W'(1);
    mc_inc_c  = mc_q + MC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rx_q     <= 1'b0;
      win_q    <= 1'b0;
      seen_q   <= 1'b0;
      hc_q     <= '0;
      mc_q     <= '0;
      locked_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      rx_q    <= bus.rx;
      win_q   <= in_win_c;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      stray_q <= stray_d;
      if (!active_c) begin
        state_q  <= IDLE;
        seen_q   <= 1'b0;
        hc_q     <= '0;
        mc_q     <= '0;
        locked_q <= 1'b0;
      end else begin
        // Close can never coincide with an in-window edge, so the order here is safe.
        if (close_c) begin
          seen_q <= 1'b0;
        end else if (hit_d) begin
          seen_q <= 1'b1;
        end
        case (state_q)
          IDLE: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
          HUNT: begin
            if (hit_d) begin
              if (hc_inc_c == HC_W'(LOCK_HITS)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                hc_q     <= '0;
                mc_q     <= '0;
              end else begin
                hc_q <= hc_inc_c;
              end
            end else if (miss_d || stray_d) begin
              hc_q <= '0;
            end
          end
          LOCKED: begin
            if (hit_d) begin
              mc_q <= '0;
            end else if (miss_d) begin
              if (mc_inc_c == MC_W'(MISS_LIMIT)) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                hc_q     <= '0;
                mc_q     <= '0;
              end else begin
                mc_q <= mc_inc_c;
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked = locked_q;
  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.stray  = stray_q;

`ifdef SCHED_RX_COUNTERS_EN
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [SUM_W-1:0] hit_sum_c;
  logic [SUM_W-1:0] err_sum_c;

  // One extra bit catches overflow; a set carry means clamp to all-ones.
  always_comb begin
    hit_sum_c = {1'b0, hit_cnt_q} + SUM_W'(hit_d);
    err_sum_c = {1'b0, err_cnt_q} + SUM_W'(miss_d) + SUM_W'(stray_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_sum_c[CNT_W] ? '1 : hit_sum_c[CNT_W-1:0];
      err_cnt_q <= err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
    end
  end

  assign bus.hitCount = hit_cnt_q;
  assign bus.errCount = err_cnt_q;
`else
  assign bus.hitCount = CNT_W'(0);
  assign bus.errCount = CNT_W'(0);
`endif

endmodule

// File: tb/tb_schedule_rx_monitor.sv
// Scoreboard bench for schedule_rx_monitor: directed GTB sweep, expected pulses queued by the driver.
module tb_schedule_rx_monitor;

  localparam int unsigned CW = 2;

  typedef struct {
    int         gtb;
    logic [7:0] v;   // {hit, miss, stray, locked, hitCount[1:0], errCount[1:0]}
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  schedule_rx_monitor_if #(.CNT_W(CW)) bus ();

  schedule_rx_monitor #(
    .WIN(4), .LOCK_HITS(2), .MISS_LIMIT(3), .CNT_W(CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cv(input logic [1:0] x);
`ifdef SCHED_RX_COUNTERS_EN
    return x;
`else
    return 2'd0 & x;
`endif
  endfunction

  task automatic push(input int g, input logic h, input logic m, input logic s,
                      input logic l, input logic [1:0] hc, input logic [1:0] ec);
    exp_t e;
    e.gtb = g;
    e.v   = {h, m, s, l, cv(hc), cv(ec)};
    sb_q.push_back(e);
  endtask

  // Driver: one GTB tick per cycle, inputs changed on the falling edge.
  initial begin
    bus.GTB           = 32'd10;
    bus.scheduleEntry = 32'd100;
    bus.rx            = 1'b0;
    for (int g = 10; g <= 1305; g++) begin
      @(negedge clk);
      bus.GTB           = 32'(g);
      rst               = (g < 13) || (g >= 1300);
      bus.scheduleEntry = (g >= 1050 && g < 1080) ? 32'd0 : ((g >= 1250) ? 32'd8 : 32'd100);
      bus.rx            = (g inside {100, 200, 300, 350, 701, 703, 800, 900, 1005,
                                     1060, 1100, 1200, 1260, 1270, 1299, 1300});
      case (g)
        100:  push(g, 1, 0, 0, 0, 2'd1, 2'd0);
        200:  push(g, 1, 0, 0, 1, 2'd2, 2'd0);
        300:  push(g, 1, 0, 0, 1, 2'd3, 2'd0);
        350:  push(g, 0, 0, 1, 1, 2'd3, 2'd1);
        405:  push(g, 0, 1, 0, 1, 2'd3, 2'd2);
        505:  push(g, 0, 1, 0, 1, 2'd3, 2'd3);
        605:  push(g, 0, 1, 0, 0, 2'd3, 2'd3);
        701:  push(g, 1, 0, 0, 0, 2'd3, 2'd3);
        703:  push(g, 0, 0, 1, 0, 2'd3, 2'd3);
        800:  push(g, 1, 0, 0, 0, 2'd3, 2'd3);
        900:  push(g, 1, 0, 0, 1, 2'd3, 2'd3);
        1005: push(g, 0, 1, 1, 1, 2'd3, 2'd3);
        1100: push(g, 1, 0, 0, 0, 2'd3, 2'd3);
        1200: push(g, 1, 0, 0, 1, 2'd3, 2'd3);
        1260: push(g, 1, 0, 0, 1, 2'd3, 2'd3);
        1270: push(g, 0, 0, 1, 1, 2'd3, 2'd3);
        1299: push(g, 0, 0, 1, 1, 2'd3, 2'd3);
        default: ;
      endcase
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected pulses never seen, need 0 (first at gtb=%0d)",
               sb_q.size(), sb_q[0].gtb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor: samples just after each rising edge, GTB still holds the sampled tick.
  always @(posedge clk) begin
    logic [7:0] got;
    exp_t       e;
    #1;
    got = {bus.hit, bus.miss, bus.stray, bus.locked, bus.hitCount, bus.errCount};
    if (bus.hit || bus.miss || bus.stray) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse: unexpected at gtb=%0d flags=%b, need no pulse", bus.GTB, got);
      end else begin
        e = sb_q.pop_front();
        if (got !== e.v || int'(bus.GTB) != e.gtb) begin
          n_bad++;
          $display("FAIL pulse: got gtb=%0d flags=%b, need gtb=%0d flags=%b",
                   bus.GTB, got, e.gtb, e.v);
        end
      end
    end
    if (bus.GTB == 32'd12 || bus.GTB == 32'd1300) begin
      n_cmp++;
      if (got !== 8'd0) begin
        n_bad++;
        $display("FAIL reset@%0d: got flags=%b, need %b", bus.GTB, got, 8'd0);
      end
    end
    if (bus.GTB == 32'd1050 || bus.GTB == 32'd1065) begin
      n_cmp++;
      if (got !== {4'b0000, cv(2'd3), cv(2'd3)}) begin
        n_bad++;
        $display("FAIL idle@%0d: got flags=%b, need %b", bus.GTB, got,
                 {4'b0000, cv(2'd3), cv(2'd3)});
      end
    end
  end

endmodule
